rx_ts_queue: RTL

- Downstream of the rx frame parser: stores receive timestamps of PTP event frames.
- Captures the SFD timestamp on the parser's trigger pulse and holds it pending.
- When the parser confirms a valid PTP frame, pushes {timestamp, frac ns, seqId, messageType, majorSdoId, sourcePortIdentity} into a show-ahead FIFO.
- Software pops the FIFO through the register bridge; the block raises a level interrupt while entries are present.

---
 rtl/rx_ts_queue.sv | 134 +++++++++++++
 1 files changed

// File: rtl/rx_ts_queue.sv
// Receive timestamp queue: arms on the SFD trigger, pushes timestamp plus PTP header
// fields into a show-ahead FIFO on the parser's valid pulse, popped by software.
module rx_ts_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic          rx_clk,
    input  logic          rx_rst_n,
    input  logic          rx_clk_en_i,
    input  logic          rxts_trig_i,
    input  logic          rxts_valid_i,
    input  logic [79:0]   sfd_timestamp_i,
    input  logic [15:0]   sfd_timestamp_frac_ns_i,
    input  logic [79:0]   rx_sourcePortIdentity_i,
    input  logic [15:0]   rx_seqId_i,
    input  logic [3:0]    rx_messageType_i,
    input  logic [3:0]    rx_majorSdoId_i,
    input  logic          rd_pop_i,
    input  logic          clr_ovf_i,
    input  logic          int_en_i,
    output logic [79:0]   head_ts_o,
    output logic [15:0]   head_frac_o,
    output logic [79:0]   head_spid_o,
    output logic [15:0]   head_seqid_o,
    output logic [3:0]    head_msgtype_o,
    output logic [3:0]    head_sdoid_o,
    output logic          empty_o,
    output logic          full_o,
    output logic [AW:0]   count_o,
    output logic          ovf_o,
    output logic [15:0]   ovf_cnt_o,
    output logic [7:0]    orphan_cnt_o,
    output logic          int_rx_ts_o
);
    localparam int unsigned EW = 200;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic {IDLE, ARMED} state_t;

    state_t        state;
    logic [79:0]   pend_ts;
    logic [15:0]   pend_frac;
    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [EW-1:0] head;

    logic valid_ev, push_req, orphan, is_empty, is_full, pop_ok, push_ok, drop;

    always_comb begin
        valid_ev = rx_clk_en_i & rxts_valid_i;
        // A valid coinciding with a trigger belongs to no armed frame: orphan it.
        push_req = valid_ev & ~rxts_trig_i & (state == ARMED);
        orphan   = valid_ev & (rxts_trig_i | (state == IDLE));
        is_empty = (count == '0);
        is_full  = (count == FULL_CNT);
        pop_ok   = rd_pop_i & ~is_empty;
        push_ok  = push_req & (~is_full | pop_ok);
        drop     = push_req & is_full & ~pop_ok;
    end

    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
        if (!rx_rst_n) begin
            state     <= IDLE;
            pend_ts   <= '0;
            pend_frac <= '0;
        end else if (rx_clk_en_i) begin
            if (rxts_trig_i) begin
                state     <= ARMED;
                pend_ts   <= sfd_timestamp_i;
                pend_frac <= sfd_timestamp_frac_ns_i;
            end else if (rxts_valid_i && state == ARMED) begin
                state <= IDLE;
            end
        end
    end

    always_ff @(posedge rx_clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= {pend_ts, pend_frac, rx_sourcePortIdentity_i, rx_seqId_i,
                            rx_messageType_i, rx_majorSdoId_i};
        end
    end

    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
        if (!rx_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
        if (!rx_rst_n) begin
            ovf_o        <= 1'b0;
            ovf_cnt_o    <= '0;
            orphan_cnt_o <= '0;
            int_rx_ts_o  <= 1'b0;
        end else begin
            // A drop in the clearing cycle survives as a fresh count of one.
            if (clr_ovf_i) begin
                ovf_o     <= drop;
                ovf_cnt_o <= drop ? 16'd1 : 16'd0;
            end else if (drop) begin
                ovf_o <= 1'b1;
                if (ovf_cnt_o != 16'hFFFF) ovf_cnt_o <= ovf_cnt_o + 16'd1;
            end
            if (orphan && orphan_cnt_o != 8'hFF) orphan_cnt_o <= orphan_cnt_o + 8'd1;
            int_rx_ts_o <= int_en_i & ~is_empty;
        end
    end

    assign head = is_empty ? '0 : mem[rd_ptr];

    assign head_ts_o      = head[199:120];
    assign head_frac_o    = head[119:104];
    assign head_spid_o    = head[103:24];
    assign head_seqid_o   = head[23:8];
    assign head_msgtype_o = head[7:4];
    assign head_sdoid_o   = head[3:0];
    assign empty_o        = is_empty;
    assign full_o         = is_full;
    assign count_o        = count;

endmodule
